demux4_stream: RTL and testbench

Registered 1-to-4 stream demultiplexer: the receiving end of the 4-way select path, and the counterpart of the combinational 4-to-1 select. A single input stream tagged with a 2-bit channel select is routed into one of four independent output channels. Each channel has a 2-entry buffer with its own valid/ready handshake. The block sits between a shared producer and four consumers, so a stalled consumer only back-pressures traffic addressed to it.

---
 rtl/demux4_pkg.sv | 17 +
 rtl/chan_fifo2.sv | 79 +++++++
 rtl/demux4_stream.sv | 47 ++++
 tb/tb_demux4_stream.sv | 243 ++++++++++++++++++++++++
 4 files changed

// File: rtl/demux4_pkg.sv
// Shared constants and types for the 1-to-4 stream demultiplexer.
package demux4_pkg;

    localparam int CH_NUM = 4;
    localparam int DEPTH  = 2;
    localparam int SEL_W  = 2;

    typedef logic [1:0] occ_t;

    // Occupancy of one channel buffer; the encoding equals the entry count.
    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        FULL  = 2'd2
    } occ_state_t;

endpackage

// File: rtl/chan_fifo2.sv
// Two-entry channel buffer with registered head, valid, full and occupancy.
// Entry 0 is always the head, so the head payload needs no output mux.
//
// state | meaning
// EMPTY | no beat held, head payload is stale
// ONE   | head valid in entry 0
// FULL  | head in entry 0, next beat in entry 1
module chan_fifo2
    import demux4_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] head_data,
    output logic             valid,
    output logic             full,
    output occ_t             occ
);

    occ_state_t       state_q, state_d;
    logic [WIDTH-1:0] mem0_q, mem0_d;
    logic [WIDTH-1:0] mem1_q, mem1_d;

    // State and storage registers; reset discards any buffered beats.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= EMPTY;
            mem0_q  <= '0;
            mem1_q  <= '0;
        end else begin
            state_q <= state_d;
            mem0_q  <= mem0_d;
            mem1_q  <= mem1_d;
        end
    end

    // Next occupancy and entry contents. Push in FULL and pop in EMPTY are
    // ignored so a misbehaving caller cannot corrupt the buffer.
    always_comb begin
        state_d = state_q;
        mem0_d  = mem0_q;
        mem1_d  = mem1_q;
        case (state_q)
            EMPTY: begin
                if (push) begin
                    mem0_d  = push_data;
                    state_d = ONE;
                end
            end
            ONE: begin
                if (push && pop) begin
                    mem0_d = push_data;
                end else if (push) begin
                    mem1_d  = push_data;
                    state_d = FULL;
                end else if (pop) begin
                    state_d = EMPTY;
                end
            end
            FULL: begin
                if (pop) begin
                    mem0_d  = mem1_q;
                    state_d = ONE;
                end
            end
            default: state_d = EMPTY;
        endcase
    end

    assign head_data = mem0_q;
    assign occ       = occ_t'(state_q);
    assign valid     = (state_q != EMPTY);
    assign full      = (occ == occ_t'(DEPTH));

endmodule

// File: rtl/demux4_stream.sv
// Registered 1-to-4 stream demultiplexer. Each channel owns a two-entry
// buffer, so only traffic addressed to a stalled consumer is held back.
module demux4_stream
    import demux4_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [WIDTH-1:0]        in_data,
    input  logic [SEL_W-1:0]        in_sel,
    input  logic                    in_valid,
    output logic                    in_ready,
    output logic [CH_NUM*WIDTH-1:0] out_data,
    output logic [CH_NUM-1:0]       out_valid,
    input  logic [CH_NUM-1:0]       out_ready,
    output logic [2*CH_NUM-1:0]     occ
);

    logic [CH_NUM-1:0] full_vec;
    logic [CH_NUM-1:0] push_vec;
    logic [CH_NUM-1:0] pop_vec;

    // Ready only looks at the selected channel's registered full flag, which
    // keeps consumer ready and producer valid out of this path.
    assign in_ready = ~full_vec[in_sel];

    for (genvar k = 0; k < CH_NUM; k++) begin : g_chan
        assign push_vec[k] = in_valid && in_ready && (in_sel == SEL_W'(k));
        assign pop_vec[k]  = out_valid[k] && out_ready[k];

        chan_fifo2 #(
            .WIDTH(WIDTH)
        ) u_fifo (
            .clk       (clk),
            .rst_n     (rst_n),
            .push      (push_vec[k]),
            .push_data (in_data),
            .pop       (pop_vec[k]),
            .head_data (out_data[k*WIDTH +: WIDTH]),
            .valid     (out_valid[k]),
            .full      (full_vec[k]),
            .occ       (occ[2*k +: 2])
        );
    end

endmodule

// File: tb/tb_demux4_stream.sv
// Directed and scoreboarded checks for demux4_stream.
module tb_demux4_stream;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [7:0]  in_data;
    logic [1:0]  in_sel;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] out_data;
    logic [3:0]  out_valid;
    logic [3:0]  out_ready;
    logic [7:0]  occ;

    int total = 0;
    int bad   = 0;

    logic [7:0] sb [4][$];
    logic [7:0] seq;
    logic [7:0] popped_beat;
    logic       exp_rdy;
    int         pushed_n;
    int         popped_n;
    int         left_n;

    demux4_stream #(.WIDTH(8)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_data   (in_data),
        .in_sel    (in_sel),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .out_data  (out_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .occ       (occ)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [7:0] head(input int k);
        return out_data[k*8 +: 8];
    endfunction

    function automatic logic [1:0] occ_of(input int k);
        return occ[2*k +: 2];
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [1:0] sel, input logic [7:0] data);
        in_valid = 1'b1;
        in_sel   = sel;
        in_data  = data;
        tick();
    endtask

    initial begin
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        in_sel    = 2'd0;
        in_data   = 8'h00;
        out_ready = 4'h0;
        #12;
        chk("rst_valid", 32'(out_valid), 32'h0);
        chk("rst_occ", 32'(occ), 32'h0);
        chk("rst_data", out_data, 32'h0);
        chk("rst_ready", 32'(in_ready), 32'h1);
        @(negedge clk);
        rst_n = 1'b1;
        tick();

        // routing: one beat per channel, consumers always ready
        out_ready = 4'hF;
        send(2'd0, 8'h10);
        chk("route0_v", 32'(out_valid), 32'h1);
        chk("route0_d", 32'(head(0)), 32'h10);
        send(2'd1, 8'h21);
        chk("route1_v", 32'(out_valid), 32'h2);
        chk("route1_d", 32'(head(1)), 32'h21);
        send(2'd2, 8'h32);
        chk("route2_v", 32'(out_valid), 32'h4);
        chk("route2_d", 32'(head(2)), 32'h32);
        send(2'd3, 8'h43);
        chk("route3_v", 32'(out_valid), 32'h8);
        chk("route3_d", 32'(head(3)), 32'h43);
        in_valid = 1'b0;
        tick();
        chk("route_idle", 32'(out_valid), 32'h0);

        // back-pressure on channel 2
        out_ready = 4'b1011;
        send(2'd2, 8'hA0);
        chk("bp_occ1", 32'(occ_of(2)), 32'd1);
        send(2'd2, 8'hA1);
        chk("bp_occ2", 32'(occ_of(2)), 32'd2);
        in_data = 8'hA2;
        #1;
        chk("bp_rdy_full", 32'(in_ready), 32'h0);
        tick();
        chk("bp_hold_occ", 32'(occ_of(2)), 32'd2);
        chk("bp_head_a0", 32'(head(2)), 32'hA0);
        out_ready = 4'hF;
        #1;
        chk("bp_rdy_nocomb", 32'(in_ready), 32'h0);
        tick();
        chk("bp_pop_occ", 32'(occ_of(2)), 32'd1);
        chk("bp_head_a1", 32'(head(2)), 32'hA1);
        chk("bp_rdy_free", 32'(in_ready), 32'h1);
        tick();
        chk("bp_pp_occ", 32'(occ_of(2)), 32'd1);
        chk("bp_head_a2", 32'(head(2)), 32'hA2);
        in_valid = 1'b0;
        tick();
        chk("bp_drained", 32'(occ), 32'h0);

        // head-of-line blocking on channel 0
        out_ready = 4'h0;
        send(2'd0, 8'hB0);
        send(2'd0, 8'hB1);
        chk("hol_occ0", 32'(occ_of(0)), 32'd2);
        in_sel  = 2'd0;
        in_data = 8'hB2;
        #1;
        chk("hol_rdy0", 32'(in_ready), 32'h0);
        in_sel  = 2'd3;
        in_data = 8'hC3;
        #1;
        chk("hol_rdy3", 32'(in_ready), 32'h1);
        tick();
        chk("hol_occ3", 32'(occ_of(3)), 32'd1);
        chk("hol_head3", 32'(head(3)), 32'hC3);
        chk("hol_occ0_keep", 32'(occ_of(0)), 32'd2);
        chk("hol_head0_keep", 32'(head(0)), 32'hB0);
        in_valid  = 1'b0;
        out_ready = 4'hF;
        tick();
        tick();
        chk("hol_drained", 32'(occ), 32'h0);

        // simultaneous push/pop on channel 3, then sustained streaming
        out_ready = 4'h0;
        send(2'd3, 8'h55);
        chk("pp_occ_55", 32'(occ_of(3)), 32'd1);
        chk("pp_head_55", 32'(head(3)), 32'h55);
        out_ready = 4'b1000;
        send(2'd3, 8'h66);
        chk("pp_occ_66", 32'(occ_of(3)), 32'd1);
        chk("pp_head_66", 32'(head(3)), 32'h66);
        for (int i = 0; i < 16; i++) begin
            send(2'd3, 8'h70 + 8'(i));
            chk("tput_occ", 32'(occ_of(3)), 32'd1);
            chk("tput_head", 32'(head(3)), 32'(8'h70 + 8'(i)));
            chk("tput_rdy", 32'(in_ready), 32'h1);
        end
        in_valid = 1'b0;
        tick();
        chk("tput_drained", 32'(occ), 32'h0);

        // asynchronous reset with channel 1 full
        out_ready = 4'h0;
        send(2'd1, 8'hD0);
        send(2'd1, 8'hD1);
        chk("mrst_pre_occ", 32'(occ_of(1)), 32'd2);
        in_valid = 1'b0;
        in_sel   = 2'd1;
        #2;
        rst_n = 1'b0;
        #1;
        chk("mrst_valid", 32'(out_valid), 32'h0);
        chk("mrst_occ", 32'(occ), 32'h0);
        chk("mrst_data", out_data, 32'h0);
        chk("mrst_ready", 32'(in_ready), 32'h1);
        #2;
        rst_n    = 1'b1;
        in_valid = 1'b1;
        in_data  = 8'hE1;
        tick();
        chk("mrst_post_v", 32'(out_valid), 32'h2);
        chk("mrst_post_d", 32'(head(1)), 32'hE1);
        chk("mrst_post_occ", 32'(occ), 32'h04);
        in_valid  = 1'b0;
        out_ready = 4'hF;
        tick();
        chk("mrst_clear", 32'(occ), 32'h0);

        // random traffic against a per-channel queue model
        seq      = 8'h00;
        pushed_n = 0;
        popped_n = 0;
        for (int c = 0; c < 3004; c++) begin
            if (c < 3000) begin
                in_valid  = 1'($urandom_range(0, 1));
                in_sel    = 2'($urandom_range(0, 3));
                out_ready = 4'($urandom_range(0, 15));
            end else begin
                in_valid  = 1'b0;
                out_ready = 4'hF;
            end
            in_data = seq;
            @(negedge clk);
            exp_rdy = (sb[in_sel].size() != 2);
            chk("rnd_rdy", 32'(in_ready), 32'(exp_rdy));
            for (int k = 0; k < 4; k++) begin
                chk("rnd_occ", 32'(occ_of(k)), 32'(sb[k].size()));
                chk("rnd_valid", 32'(out_valid[k]), 32'(sb[k].size() > 0));
                if (sb[k].size() > 0) begin
                    chk("rnd_head", 32'(head(k)), 32'(sb[k][0]));
                    if (out_ready[k]) begin
                        popped_beat = sb[k].pop_front();
                        popped_n++;
                    end
                end
            end
            if (in_valid && exp_rdy) begin
                sb[in_sel].push_back(seq);
                seq = seq + 8'd1;
                pushed_n++;
            end
            @(posedge clk);
            #1;
        end
        left_n = sb[0].size() + sb[1].size() + sb[2].size() + sb[3].size();
        chk("rnd_end_occ", 32'(occ), 32'h0);
        chk("rnd_end_model", 32'(left_n), 32'd0);
        chk("rnd_conserve", 32'(popped_n), 32'(pushed_n));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
